des_round_ctrl: RTL and testbench

- Sequencer for the iterative DES Feistel datapath: the L/R round mux, the f-function and the round-key select.
- Accepts one block per valid/ready handshake and loads initial L/R.
- Steps 16 rounds, one per clock, and drives the round counter and subkey index (forward for encrypt, reversed for decrypt).
- Presents a held done/valid handshake to the output stage.

---
 rtl/des_pkg.sv | 17 +
 rtl/des_round_counter.sv | 19 +
 rtl/des_round_ctrl.sv | 72 +++++++
 tb/tb_des_round_ctrl.sv | 141 ++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// des_pkg: shared constants, state encoding and subkey-index helper for the DES round controller.
package des_pkg;
    localparam int DES_ROUNDS = 16;
    localparam int DES_CNT_W  = 5;
    localparam int DES_KIDX_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    // Decrypt walks the key schedule backwards.
    function automatic int subkey_idx(input int cnt, input logic mode, input int rounds);
        return mode ? rounds - 1 - cnt : cnt;
    endfunction
endpackage

// File: rtl/des_round_counter.sv
// des_round_counter: round counter with synchronous clear and a last-round flag.
module des_round_counter #(
    parameter int ROUNDS = des_pkg::DES_ROUNDS,
    parameter int CNT_W  = des_pkg::DES_CNT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt,
    output logic             cnt_last
);
    always_ff @(posedge clk) begin
        if (rst || clr) cnt <= '0;
        else if (inc) cnt <= cnt + 1'b1;
    end

    assign cnt_last = cnt == CNT_W'(ROUNDS - 1);
endmodule

// File: rtl/des_round_ctrl.sv
// des_round_ctrl: sequences one DES block through ROUNDS Feistel rounds with
// valid/ready handshakes on both sides.
module des_round_ctrl #(
    parameter int ROUNDS = des_pkg::DES_ROUNDS,
    parameter int CNT_W  = des_pkg::DES_CNT_W,
    parameter int KIDX_W = des_pkg::DES_KIDX_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              decrypt,
    output logic              load_init,
    output logic              round_en,
    output logic [CNT_W-1:0]  cnt,
    output logic [KIDX_W-1:0] key_idx,
    output logic              last_round,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              busy
);
    import des_pkg::*;

    state_t state;
    logic   mode_r;
    logic   cnt_last;
    logic   run;
    logic   done;
    logic   clr;

    assign run  = state == RUN;
    assign done = state == DONE;
    // Every accept and every drain of DONE restarts the count.
    assign clr  = (state == IDLE && in_valid) || (done && out_ready);

    des_round_counter #(.ROUNDS(ROUNDS), .CNT_W(CNT_W)) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .clr      (clr),
        .inc      (run),
        .cnt      (cnt),
        .cnt_last (cnt_last)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            mode_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    state  <= RUN;
                    mode_r <= decrypt;
                end
                RUN: if (cnt_last) state <= DONE;
                DONE: if (out_ready) begin
                    state <= in_valid ? RUN : IDLE;
                    if (in_valid) mode_r <= decrypt;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready   = state == IDLE || (done && out_ready);
    assign round_en   = run;
    assign load_init  = run && cnt == '0;
    assign key_idx    = run ? KIDX_W'(subkey_idx(int'(cnt), mode_r, ROUNDS)) : '0;
    assign last_round = run && cnt_last;
    assign out_valid  = done;
    assign busy       = run || done;
endmodule

// File: tb/tb_des_round_ctrl.sv
// tb_des_round_ctrl: cycle-by-cycle vector table for des_round_ctrl, checked
// through an expected-output queue sampled on the falling edge.
module tb_des_round_ctrl;
    typedef struct {
        int          seq;
        logic        chk;
        logic        rst;
        logic        in_valid;
        logic        decrypt;
        logic        out_ready;
        logic [14:0] exp;
    } vec_t;

    logic       clk = 1'b0;
    logic       rst, in_valid, decrypt, out_ready;
    logic       in_ready, load_init, round_en, last_round, out_valid, busy;
    logic [4:0] cnt;
    logic [3:0] key_idx;
    logic [14:0] act;

    vec_t vecs[$];
    vec_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   row = 0;

    always #5 clk = ~clk;

    des_round_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .decrypt    (decrypt),
        .load_init  (load_init),
        .round_en   (round_en),
        .cnt        (cnt),
        .key_idx    (key_idx),
        .last_round (last_round),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    assign act = {in_ready, load_init, round_en, cnt, key_idx, last_round, out_valid, busy};

    function automatic logic [14:0] pk(input logic ir, input logic li, input logic re, input int c,
                                       input int k, input logic lr, input logic ov, input logic b);
        return {ir, li, re, 5'(c), 4'(k), lr, ov, b};
    endfunction

    function automatic void add(input int seq, input logic chk, input logic r, input logic iv,
                                input logic dec, input logic ordy, input logic [14:0] e);
        vec_t v;
        v.seq = seq; v.chk = chk; v.rst = r; v.in_valid = iv;
        v.decrypt = dec; v.out_ready = ordy; v.exp = e;
        vecs.push_back(v);
    endfunction

    function automatic void idle_row(input int seq, input logic r, input logic iv, input logic dec);
        add(seq, 1'b1, r, iv, dec, 1'b1, pk(1, 0, 0, 0, 0, 0, 0, 0));
    endfunction

    function automatic void run_row(input int seq, input int i, input logic m, input logic r,
                                    input logic iv, input logic dec);
        add(seq, 1'b1, r, iv, dec, 1'b1, pk(0, i == 0, 1, i, m ? 15 - i : i, i == 15, 0, 1));
    endfunction

    function automatic void done_row(input int seq, input logic iv, input logic dec, input logic ordy);
        add(seq, 1'b1, 1'b0, iv, dec, ordy, pk(ordy, 0, 0, 16, 0, 0, 1, 1));
    endfunction

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            vec_t v;
            v = sb.pop_front();
            if (v.chk) begin
                checks++;
                if (act !== v.exp) begin
                    errors++;
                    $display("FAIL seq%0d row%0d {ir,li,re,cnt,kidx,lr,ov,busy}: got %b_%b_%b_%0d_%0d_%b_%b_%b want %b_%b_%b_%0d_%0d_%b_%b_%b",
                             v.seq, row, act[14], act[13], act[12], act[11:7], act[6:3], act[2], act[1], act[0],
                             v.exp[14], v.exp[13], v.exp[12], v.exp[11:7], v.exp[6:3], v.exp[2], v.exp[1], v.exp[0]);
                end
            end
            row++;
        end
    end

    initial begin
        rst = 1'b1; in_valid = 1'b0; decrypt = 1'b0; out_ready = 1'b1;
        // Encrypt single block after a two-cycle reset.
        add(1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, '0);
        idle_row(1, 1, 0, 0);
        idle_row(1, 0, 0, 0);
        idle_row(1, 0, 1, 0);
        for (int i = 0; i < 16; i++) run_row(1, i, 0, 0, 0, 0);
        done_row(1, 0, 0, 1);
        idle_row(1, 0, 0, 0);
        // Decrypt with decrypt toggling during the run.
        idle_row(2, 0, 1, 1);
        for (int i = 0; i < 16; i++) run_row(2, i, 1, 0, 0, i % 2 == 0);
        done_row(2, 0, 0, 1);
        idle_row(2, 0, 0, 0);
        // Output backpressure with in_valid poking at a stalled DONE.
        idle_row(3, 0, 1, 0);
        for (int i = 0; i < 16; i++) run_row(3, i, 0, 0, 0, 0);
        for (int k = 0; k < 5; k++) done_row(3, k % 2 == 0, 1, 0);
        done_row(3, 0, 0, 1);
        idle_row(3, 0, 0, 0);
        // Back-to-back: enc, dec, enc with in_valid and out_ready held high.
        idle_row(4, 0, 1, 0);
        for (int b = 0; b < 3; b++) begin
            for (int i = 0; i < 16; i++) run_row(4, i, b == 1, 0, 1, b == 0);
            if (b < 2) done_row(4, 1, b == 0, 1);
            else done_row(4, 0, 0, 1);
        end
        idle_row(4, 0, 0, 0);
        // Ignored in_valid at cnt 3, reset at cnt 7, then no stray out_valid.
        idle_row(5, 0, 1, 0);
        for (int i = 0; i < 8; i++) run_row(5, i, 0, i == 7, i == 3, 0);
        for (int k = 0; k < 20; k++) idle_row(5, 0, 0, 0);

        foreach (vecs[n]) begin
            @(posedge clk);
            #1;
            rst = vecs[n].rst; in_valid = vecs[n].in_valid;
            decrypt = vecs[n].decrypt; out_ready = vecs[n].out_ready;
            sb.push_back(vecs[n]);
        end
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending want 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
